// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative signed 32-bit shift-add multiply / restoring divide, 32 cycles per op.
// Define MULTDIV_EXCEPTION_EN to build the overflow / divide-by-zero flag; otherwise data_exception is 0.
module multdiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, res_q, res_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] mag_a, mag_b, diff, step_hi, step_lo, sres, fin;
  logic [WIDTH:0]   sum, sh;
  logic             ge, is_div, last, start;
  // hi:lo is the running product for multiply and remainder:dividend-shift for divide
  always_comb begin
    mag_a   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    mag_b   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    is_div  = state_q == DIV;
    sum     = {1'b0, hi_q} + {1'b0, lo_q[0] ? b_q : {WIDTH{1'b0}}};
    sh      = {hi_q, lo_q[WIDTH-1]};
    ge      = sh >= {1'b0, b_q};
    diff    = sh[WIDTH-1:0] - b_q;
    step_hi = is_div ? (ge ? diff : sh[WIDTH-1:0]) : sum[WIDTH:1];
    step_lo = is_div ? {lo_q[WIDTH-2:0], ge} : {sum[0], lo_q[WIDTH-1:1]};
    sres    = sign_q ? -step_lo : step_lo;
    fin     = (is_div && b_q == '0) ? '0 : sres;
    last    = cnt_q == '1;
    start   = (state_q == IDLE || state_q == DONE) && (ctrl_MULT || ctrl_DIV);
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    sign_d  = sign_q;
    res_d   = res_q;
    if (start) begin
      state_d = ctrl_MULT ? MULT : DIV;
      cnt_d   = '0;
      hi_d    = '0;
      lo_d    = mag_a;
      b_d     = mag_b;
      sign_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
    end else if (busy) begin
      cnt_d   = cnt_q + 1'b1;
      hi_d    = step_hi;
      lo_d    = step_lo;
      state_d = last ? DONE : state_q;
      res_d   = last ? fin : res_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
    end
  end
  assign data_result    = res_q;
  assign data_resultRDY = state_q == DONE;
  assign busy           = state_q == MULT || state_q == DIV;
`ifdef MULTDIV_EXCEPTION_EN
  logic exc_q, exc_d, ovf;
  // signed range is [-2^(W-1), 2^(W-1)-1]; the negative side admits one extra magnitude
  assign ovf = is_div ? (b_q == '0 || (!sign_q && step_lo[WIDTH-1]))
                      : (|step_hi || (step_lo[WIDTH-1] && (!sign_q || |step_lo[WIDTH-2:0])));
  assign exc_d = (busy && last) ? ovf : exc_q;
  always_ff @(posedge clk) begin
    if (clr) exc_q <= 1'b0;
    else exc_q <= exc_d;
  end
  assign data_exception = exc_q;
`else
  assign data_exception = 1'b0;
`endif
endmodule

// File: tb/tb_multdiv_iter.sv
// tb_multdiv_iter: directed and random checks of multdiv_iter against an arithmetic reference model.
module tb_multdiv_iter;
  logic        clk = 1'b0, clr, cm, cd;
  logic [31:0] a, b, res;
  logic        exc, rdy, busy;
  int          vectors = 0, errors = 0;
  logic [31:0] last_res = '0;

  multdiv_iter dut (
    .clk(clk), .clr(clr), .ctrl_MULT(cm), .ctrl_DIV(cd),
    .data_operandA(a), .data_operandB(b),
    .data_result(res), .data_exception(exc), .data_resultRDY(rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input bit m, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic e);
    int     sx, sy;
    longint p;
    sx = x;
    sy = y;
    if (m) begin
      p = longint'(sx) * longint'(sy);
      r = p[31:0];
      e = p > 64'sd2147483647 || p < -64'sd2147483648;
    end else if (sy == 0) begin
      r = 32'h0;
      e = 1'b1;
    end else if (sx == 32'h80000000 && sy == -1) begin
      r = 32'h80000000;
      e = 1'b1;
    end else begin
      r = sx / sy;
      e = 1'b0;
    end
`ifndef MULTDIV_EXCEPTION_EN
    e = 1'b0;
`endif
  endfunction

  task automatic run_op(input bit m, input bit d, input logic [31:0] x, input logic [31:0] y,
                        input int poke, input string tag);
    logic [31:0] er;
    logic        ee;
    int          n;
    bit          busy_ok;
    model(m, x, y, er, ee);
    cm = m; cd = d; a = x; b = y;
    tick;
    cm = 0; cd = 0; a = $urandom; b = $urandom;
    check({tag, " busy_start"}, busy, 1);
    check({tag, " hold_old"}, res, last_res);
    n = 0;
    busy_ok = 1;
    while (!rdy && n < 40) begin
      if (n == poke) cd = 1;
      tick;
      cd = 0;
      n++;
      if (!rdy && !busy) busy_ok = 0;
    end
    check({tag, " latency"}, n, 32);
    check({tag, " busy_thru"}, busy_ok, 1);
    check({tag, " busy_done"}, busy, 0);
    check({tag, " result"}, res, er);
    check({tag, " exc"}, exc, ee);
    last_res = er;
  endtask

  task automatic settle(input string tag);
    tick;
    check({tag, " rdy_1cyc"}, rdy, 0);
    check({tag, " idle"}, busy, 0);
  endtask

  initial begin
    bit seen;
    bit m;
    logic [31:0] x, y;
    clr = 1; cm = 0; cd = 0; a = 0; b = 0;
    tick;
    tick;
    check("rst result", res, 0);
    check("rst exc", exc, 0);
    check("rst rdy", rdy, 0);
    check("rst busy", busy, 0);
    clr = 0;
    tick;
    check("post rst rdy", rdy, 0);
    run_op(1, 0, 32'd7, -32'sd3, -1, "mul 7x-3");
    settle("mul 7x-3");
    run_op(1, 0, 32'h00010000, 32'h00010000, -1, "mul ovf");
    settle("mul ovf");
    run_op(0, 1, -32'sd7, 32'd2, -1, "div -7/2");
    settle("div -7/2");
    run_op(0, 1, 32'd5, 32'd0, -1, "div 5/0");
    settle("div 5/0");
    run_op(0, 1, 32'h80000000, 32'hFFFFFFFF, -1, "div min/-1");
    settle("div min/-1");
    run_op(1, 0, 32'h80000000, 32'hFFFFFFFF, -1, "mul min*-1");
    settle("mul min*-1");
    run_op(1, 1, 32'd1234, -32'sd99, -1, "both high");
    settle("both high");
    run_op(1, 0, 32'd100, 32'd200, 10, "div poke");
    settle("div poke");
    run_op(1, 0, 32'd3, 32'd5, -1, "b2b first");
    run_op(1, 0, -32'sd11, 32'd13, -1, "b2b second");
    settle("b2b second");
    cm = 1; a = 32'd9; b = 32'd9;
    tick;
    cm = 0;
    repeat (10) tick;
    clr = 1;
    tick;
    clr = 0;
    check("clr busy", busy, 0);
    check("clr result", res, 0);
    check("clr rdy", rdy, 0);
    check("clr exc", exc, 0);
    last_res = '0;
    seen = 0;
    repeat (40) begin
      tick;
      if (rdy) seen = 1;
    end
    check("clr no rdy", seen, 0);
    for (int i = 0; i < 30; i++) begin
      m = 1'($urandom_range(0, 1));
      x = $urandom;
      y = $urandom;
      if (i % 3 == 1) y = $urandom_range(0, 40) - 20;
      if (i % 5 == 2) x = $urandom_range(0, 70000) - 35000;
      if (i % 7 == 3) y = 0;
      run_op(m, !m, x, y, -1, m ? "rand mul" : "rand div");
      if ($urandom_range(0, 1) == 1) settle("rand");
    end
    settle("final");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
